// File: rtl/logic_op_arbiter.sv
// Four-requester round-robin arbiter in front of a one-deep result register.
// Each requester asks for a bitwise logic op on its own operands; the granted result is held until accepted.

module logic_op_unit #(
   parameter int W = 8
) (
   input  logic [2:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_y,
   output logic         o_err
);
   always_comb begin
      o_y   = '0;
      o_err = 1'b0;
      case (i_op)
         3'd0:    o_y = i_a & i_b;
         3'd1:    o_y = i_a | i_b;
         3'd2:    o_y = ~i_a;
         3'd3:    o_y = ~(i_a & i_b);
         3'd4:    o_y = ~(i_a | i_b);
         3'd5:    o_y = i_a ^ i_b;
         3'd6:    o_y = ~(i_a ^ i_b);
         default: o_err = 1'b1;
      endcase
   end
endmodule

module logic_op_arbiter #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     req,
   input  logic [11:0]    op,
   input  logic [4*W-1:0] a,
   input  logic [4*W-1:0] b,
   output logic [3:0]     gnt,
   output logic [W-1:0]   y,
   output logic           y_vld,
   input  logic           y_rdy,
   output logic [1:0]     y_id,
   output logic           err
);
   localparam int NUM_LANES = 4;

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;
   typedef struct packed {
      logic [W-1:0] y;
      logic         err;
   } res_t;

   state_t                r_state;
   logic [1:0]            r_ptr;
   logic [W-1:0]          r_y;
   logic [1:0]            r_id;
   logic                  r_err;

   res_t [NUM_LANES-1:0]  w_res;
   logic [1:0]            w_gnt_idx;
   logic                  w_any;
   logic                  w_accept;
   logic                  w_grant;

   // Every lane computes its result in parallel; the grant just picks one.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic_op_unit #(.W(W)) u_unit (
            .i_op  (op[3*gi +: 3]),
            .i_a   (a[W*gi +: W]),
            .i_b   (b[W*gi +: W]),
            .o_y   (w_res[gi].y),
            .o_err (w_res[gi].err)
         );
      end
   endgenerate

   // Search starts at the pointer; the first set request wins.
   always_comb begin
      w_gnt_idx = r_ptr;
      w_any     = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!w_any && req[r_ptr + 2'(k)]) begin
            w_any     = 1'b1;
            w_gnt_idx = r_ptr + 2'(k);
         end
      end
   end

   assign w_accept = (r_state == S_EMPTY) || y_rdy;
   assign w_grant  = !rst && w_accept && w_any;
   assign gnt      = w_grant ? (4'b0001 << w_gnt_idx) : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_ptr   <= '0;
         r_y     <= '0;
         r_id    <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_y     <= w_res[w_gnt_idx].y;
            r_err   <= w_res[w_gnt_idx].err;
            r_id    <= w_gnt_idx;
            r_ptr   <= w_gnt_idx + 2'd1;
            r_state <= S_FULL;
         end else begin
            case (r_state)
               S_FULL:  if (y_rdy) r_state <= S_EMPTY;
               default: r_state <= S_EMPTY;
            endcase
         end
      end
   end

   assign y     = r_y;
   assign y_id  = r_id;
   assign err   = r_err;
   assign y_vld = (r_state == S_FULL);
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: reset, fairness, single op, backpressure, opcodes, reset mid-op.

module tb_logic_op_arbiter;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req;
   logic [11:0]    op;
   logic [4*W-1:0] a;
   logic [4*W-1:0] b;
   logic [3:0]     gnt;
   logic [W-1:0]   y;
   logic           y_vld;
   logic           y_rdy;
   logic [1:0]     y_id;
   logic           err;

   int n_chk  = 0;
   int n_fail = 0;

   logic_op_arbiter #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .op    (op),
      .a     (a),
      .b     (b),
      .gnt   (gnt),
      .y     (y),
      .y_vld (y_vld),
      .y_rdy (y_rdy),
      .y_id  (y_id),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [2:0] o, input logic [W-1:0] av,
                           input logic [W-1:0] bv);
      op[3*i +: 3] = o;
      a[W*i +: W]  = av;
      b[W*i +: W]  = bv;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [W-1:0] ey,
                          input logic [1:0] eid, input logic eerr);
      chk({tag, ".vld"}, 32'(y_vld), 32'(v));
      chk({tag, ".y"},   32'(y),     32'(ey));
      chk({tag, ".id"},  32'(y_id),  32'(eid));
      chk({tag, ".err"}, 32'(err),   32'(eerr));
   endtask

   logic [3:0]   f_gnt [5];
   logic [W-1:0] f_y   [5];
   logic [1:0]   f_id  [5];
   logic         f_err [5];
   logic [W-1:0] o_y   [8];

   initial begin
      rst = 1'b1; req = '0; op = '0; a = '0; b = '0; y_rdy = 1'b0;
      tick(); tick();
      chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
      req = 4'b1111;
      #1 chk("rst_gnt", 32'(gnt), 32'h0);

      // Fairness; first grant after reset release goes to requester 0
      set_lane(0, 3'd0, 8'hF0, 8'h3C);
      set_lane(1, 3'd1, 8'h0F, 8'h30);
      set_lane(2, 3'd6, 8'hAA, 8'h0F);
      set_lane(3, 3'd7, 8'h12, 8'h34);
      f_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      f_y   = '{8'h30, 8'h3F, 8'h5A, 8'h00, 8'h30};
      f_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      f_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tick();
      rst = 1'b0; y_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("fair_gnt%0d", k), 32'(gnt), 32'(f_gnt[k]));
         tick();
         chk_out($sformatf("fair%0d", k), 1'b1, f_y[k], f_id[k], f_err[k]);
      end

      // FULL, y_rdy=1, no request -> EMPTY
      req = '0;
      #1 chk("drain_gnt", 32'(gnt), 32'h0);
      tick();
      chk("drain_vld", 32'(y_vld), 32'h0);

      // Single op with y_rdy ignored in EMPTY; pointer=1 wraps to 0
      y_rdy = 1'b0;
      req = 4'b0001;
      set_lane(0, 3'd5, 8'hF0, 8'h3C);
      #1 chk("single_gnt", 32'(gnt), 32'b0001);
      tick();
      chk_out("single", 1'b1, 8'hCC, 2'd0, 1'b0);

      // Backpressure
      req = 4'b0010;
      set_lane(1, 3'd0, 8'hFF, 8'h3C);
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("bp_gnt%0d", k), 32'(gnt), 32'h0);
         tick();
         chk_out($sformatf("bp%0d", k), 1'b1, 8'hCC, 2'd0, 1'b0);
      end
      y_rdy = 1'b1;
      #1 chk("bp_rel_gnt", 32'(gnt), 32'b0010);
      tick();
      chk_out("bp_rel", 1'b1, 8'h3C, 2'd1, 1'b0);

      // All opcodes back to back
      o_y = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
      req = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         set_lane(0, 3'(k), 8'hA5, 8'h0F);
         #1 chk($sformatf("op%0d_gnt", k), 32'(gnt), 32'b0001);
         tick();
         chk_out($sformatf("op%0d", k), 1'b1, o_y[k], 2'd0, (k == 7));
      end

      // Reset mid-operation; pointer left at 3 before reset
      req = 4'b0100;
      set_lane(2, 3'd5, 8'hF0, 8'h3C);
      #1 chk("pre_rst_gnt", 32'(gnt), 32'b0100);
      tick();
      chk_out("pre_rst", 1'b1, 8'hCC, 2'd2, 1'b0);
      req = '0; y_rdy = 1'b0;
      tick();
      chk_out("hold", 1'b1, 8'hCC, 2'd2, 1'b0);
      rst = 1'b1; req = 4'b1100;
      #1 chk("mid_rst_gnt", 32'(gnt), 32'h0);
      tick();
      chk_out("mid_rst", 1'b0, 8'h00, 2'd0, 1'b0);
      rst = 1'b0;
      #1 chk("post_rst_gnt", 32'(gnt), 32'b0100);
      tick();
      chk_out("post_rst", 1'b1, 8'hCC, 2'd2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, operand and result width in bits (W >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port op  input  12  opcode, 3 bits per requester; requester i uses op[3i+2:3i].
REQ-006 SHALL have port a  input  4*W  operand A; requester i uses a[W*i+W-1:W*i].
REQ-007 SHALL have port b  input  4*W  operand B, same slicing as a.
REQ-008 SHALL have port gnt  output  4  one-hot grant; gnt[i]=1 marks the cycle in which requester i's operation is accepted.
REQ-009 SHALL have port y  output  W  result of the accepted operation.
REQ-010 SHALL have port y_vld  output  1  y, y_id and err are valid.
REQ-011 SHALL have port y_rdy  input  1  downstream accepts the result.
REQ-012 SHALL have port y_id  output  2  index of the requester that owns y.
REQ-013 SHALL have port err  output  1  the operation in y used an illegal opcode.

Function
REQ-014 SHALL encode opcodes as 0 AND, 1 OR, 2 NOT (~a; b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, all bitwise over W bits.
REQ-015 SHALL treat opcode 7 as illegal: y=0, err=1; every legal opcode gives err=0.
REQ-016 SHALL implement a two-state FSM: EMPTY (y_vld=0) and FULL (y_vld=1).
REQ-017 SHALL define accept = (state==EMPTY) or (state==FULL and y_rdy==1).
REQ-018 SHALL assert gnt combinationally, at most one bit, only when accept==1 and req is nonzero; gnt=0 otherwise.
REQ-019 SHALL select the grantee round-robin: search starts at pointer p, order p, p+1, p+2, p+3 mod 4; the first set req bit wins.
REQ-020 SHALL set p to (granted index + 1) mod 4 on each grant edge and hold p when there is no grant.
REQ-021 SHALL, on a grant edge, register y = op(a_i, b_i), y_id = i, err per REQ-015, and enter or remain in FULL; latency from gnt to y_vld is 1 cycle.
REQ-022 SHALL, when FULL with y_rdy=1 and no grant, return to EMPTY; when FULL with y_rdy=0, hold y, y_id, err and y_vld unchanged, with gnt=0.
REQ-023 SHALL, when FULL with y_rdy=1 and a grant in the same cycle, replace the result with no bubble, giving full throughput of 1 op/cycle.
REQ-024 SHALL leave the output registers unchanged in EMPTY with no request; y_rdy is ignored in EMPTY.
REQ-025 SHALL keep a requester's req asserted with stable op, a and b until its gnt cycle; dropping req earlier withdraws the request with no side effects.

Reset
REQ-026 SHALL, on clk edge with rst=1, set state=EMPTY, y_vld=0, y=0, y_id=0, err=0, p=0.
REQ-027 SHALL force gnt=0 while rst=1, and SHALL discard any in-flight result on reset mid-operation (FULL with y_rdy=0).
REQ-028 SHALL, in the first cycle after rst deasserts, grant requester 0 if req[0]=1.

Verification
REQ-029 SHALL cover single op: W=8, req=0001, op0=5, a0=F0, b0=3C, y_rdy=1 -> gnt=0001 in that cycle; next cycle y_vld=1, y=CC, y_id=0, err=0.
REQ-030 SHALL cover fairness: req=1111 held, y_rdy=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, y_vld=1 continuously from the 2nd cycle.
REQ-031 SHALL cover backpressure: FULL with y_rdy=0 for 3 cycles while req=0010 -> gnt=0000, and y, y_id stable for 3 cycles; y_rdy=1 -> gnt=0010 in that cycle, with the new result on the next cycle.
REQ-032 SHALL cover opcodes: each of 0..7 with a=A5, b=0F -> y=05, AF, 5A, FA, 50, AA, 55, 00; err=1 only for opcode 7.
REQ-033 SHALL cover reset mid-operation: rst=1 while FULL, y_rdy=0 -> next cycle y_vld=0, y=00, p=0; after release, req=1100 -> gnt=0100.
